// File: rtl/instr_enc_pkg.sv
`default_nettype none
// ============================================================================
// Module  : instr_enc_pkg
// Brief   : Class codes, RV32I opcodes and loader FSM encoding.
// Revision: 1.0
// ============================================================================
package instr_enc_pkg;

    localparam logic [2:0] CLS_LW  = 3'd0;
    localparam logic [2:0] CLS_SW  = 3'd1;
    localparam logic [2:0] CLS_R   = 3'd2;
    localparam logic [2:0] CLS_B   = 3'd3;
    localparam logic [2:0] CLS_I   = 3'd4;
    localparam logic [2:0] CLS_LUI = 3'd5;
    localparam logic [2:0] CLS_JAL = 3'd6;

    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_RTYPE  = 7'b0110011;
    localparam logic [6:0] OP_ITYPE  = 7'b0010011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;

    localparam logic [2:0] F3_WORD = 3'b010;
    localparam logic [2:0] F3_SLL  = 3'b001;
    localparam logic [2:0] F3_SRL  = 3'b101;
    localparam logic [6:0] F7_ALT  = 7'b0100000;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_LOAD  = 2'd1;
    localparam logic [1:0] ST_DRAIN = 2'd2;
    localparam logic [1:0] ST_DONE  = 2'd3;

    // True when v is representable as a two's-complement number of n bits.
    function automatic logic fits_signed(input logic [31:0] v, input int n);
        logic signed [31:0] sh;
        sh = $signed(v) >>> (n - 1);
        return (sh == '0) || (sh == '1);
    endfunction

endpackage
`default_nettype wire

// File: rtl/instr_encoder_loader_pack.sv
`default_nettype none
// ============================================================================
// Module  : instr_pack
// Brief   : Combinational RV32I field packer with immediate range checking.
// Revision: 1.0
// ============================================================================
module instr_pack
    import instr_enc_pkg::*;
(
    input  logic [2:0]  cls,
    input  logic [4:0]  rd,
    input  logic [4:0]  rs1,
    input  logic [4:0]  rs2,
    input  logic [2:0]  funct3,
    input  logic        alt,
    input  logic [31:0] imm,
    output logic [31:0] word,
    output logic        illegal
);

    logic [6:0] w_f7;
    logic       w_shift;

    assign w_f7    = alt ? F7_ALT : 7'b0;
    assign w_shift = (funct3 == F3_SLL) || (funct3 == F3_SRL);

    always_comb begin
        word    = '0;
        illegal = 1'b0;
        case (cls)
            CLS_LW: begin
                word    = {imm[11:0], rs1, F3_WORD, rd, OP_LOAD};
                illegal = !fits_signed(imm, 12);
            end
            CLS_SW: begin
                word    = {imm[11:5], rs2, rs1, F3_WORD, imm[4:0], OP_STORE};
                illegal = !fits_signed(imm, 12);
            end
            CLS_R: begin
                word = {w_f7, rs2, rs1, funct3, rd, OP_RTYPE};
            end
            CLS_I: begin
                if (w_shift) begin
                    word    = {w_f7, imm[4:0], rs1, funct3, rd, OP_ITYPE};
                    illegal = (imm[31:5] != '0);
                end else begin
                    word    = {imm[11:0], rs1, funct3, rd, OP_ITYPE};
                    illegal = !fits_signed(imm, 12);
                end
            end
            CLS_B: begin
                word    = {imm[12], imm[10:5], rs2, rs1, funct3,
                           imm[4:1], imm[11], OP_BRANCH};
                illegal = !fits_signed(imm, 13) || imm[0];
            end
            CLS_LUI: begin
                word    = {imm[31:12], rd, OP_LUI};
                illegal = (imm[11:0] != '0);
            end
            CLS_JAL: begin
                word    = {imm[20], imm[10:1], imm[11], imm[19:12], rd, OP_JAL};
                illegal = !fits_signed(imm, 21) || imm[0];
            end
            default: illegal = 1'b1;
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/instr_encoder_loader.sv
`default_nettype none
// ============================================================================
// Module  : instr_encoder_loader
// Brief   : Encodes instruction commands and streams them into instruction
//           memory through a small FIFO and a write/ack handshake.
// Revision: 1.0
// ============================================================================
module instr_encoder_loader
    import instr_enc_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR  = 32'h0000_0000,
    parameter int          MEM_WORDS  = 1024,
    parameter int          FIFO_DEPTH = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic        cmd_last,
    input  logic [2:0]  cmd_cls,
    input  logic [4:0]  cmd_rd,
    input  logic [4:0]  cmd_rs1,
    input  logic [4:0]  cmd_rs2,
    input  logic [2:0]  cmd_funct3,
    input  logic        cmd_alt,
    input  logic [31:0] cmd_imm,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic        mem_ack,
    output logic        busy,
    output logic        done,
    output logic        err,
    output logic [31:0] words_written
);

    localparam int             c_aw        = $clog2(FIFO_DEPTH);
    localparam logic [c_aw:0]  c_full      = (c_aw + 1)'(FIFO_DEPTH);
    localparam logic [31:0]    c_last_addr = BASE_ADDR + 32'(4 * (MEM_WORDS - 1));

    logic [1:0]      r_state;
    logic [31:0]     r_fifo [FIFO_DEPTH];
    logic [c_aw-1:0] r_wr_ptr;
    logic [c_aw-1:0] r_rd_ptr;
    logic [c_aw:0]   r_count;
    logic [31:0]     r_addr;
    logic [31:0]     r_words;
    logic            r_err;

    logic [31:0] w_word;
    logic        w_illegal;
    logic        w_full;
    logic        w_empty;
    logic        w_accept;
    logic        w_push;
    logic        w_pop;

    instr_pack u_pack (
        .cls     (cmd_cls),
        .rd      (cmd_rd),
        .rs1     (cmd_rs1),
        .rs2     (cmd_rs2),
        .funct3  (cmd_funct3),
        .alt     (cmd_alt),
        .imm     (cmd_imm),
        .word    (w_word),
        .illegal (w_illegal)
    );

    assign w_full   = (r_count == c_full);
    assign w_empty  = (r_count == '0);
    assign w_accept = cmd_valid && cmd_ready;
    assign w_push   = w_accept && !w_illegal;
    assign w_pop    = !w_empty && mem_ack;

    // The FIFO head is the write port: it holds until popped by an ack.
    assign cmd_ready     = (r_state == ST_LOAD) && !w_full;
    assign mem_we        = !w_empty;
    assign mem_wdata     = w_empty ? 32'h0 : r_fifo[r_rd_ptr];
    assign mem_addr      = r_addr;
    assign busy          = (r_state != ST_IDLE);
    assign done          = (r_state == ST_DONE);
    assign err           = r_err;
    assign words_written = r_words;

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_fifo[r_wr_ptr] <= w_word;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= ST_IDLE;
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            r_addr   <= BASE_ADDR;
            r_words  <= '0;
            r_err    <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (start) begin
                        r_state <= ST_LOAD;
                        r_err   <= 1'b0;
                        r_words <= '0;
                        r_addr  <= BASE_ADDR;
                    end
                end
                ST_LOAD: begin
                    if (w_accept && cmd_last) begin
                        r_state <= ST_DRAIN;
                    end
                end
                ST_DRAIN: begin
                    if (w_empty) begin
                        r_state <= ST_DONE;
                    end
                end
                ST_DONE:  r_state <= ST_IDLE;
                default:  r_state <= ST_IDLE;
            endcase

            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            if (w_push && !w_pop) begin
                r_count <= r_count + 1'b1;
            end else if (!w_push && w_pop) begin
                r_count <= r_count - 1'b1;
            end

            if (w_pop) begin
                r_words <= r_words + 32'd1;
                if (r_addr == c_last_addr) begin
                    r_addr <= BASE_ADDR;
                    r_err  <= 1'b1;
                end else begin
                    r_addr <= r_addr + 32'd4;
                end
            end

            if (w_accept && w_illegal) begin
                r_err <= 1'b1;
            end
        end
    end

endmodule
`default_nettype wire
